// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker architectural register file.
package tinker_pkg;

  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned REG_COUNT      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef logic signed [DATA_WIDTH-1:0] reg_word_t;
  typedef logic [REG_ADDR_WIDTH-1:0]    reg_addr_t;

  localparam reg_addr_t SP_INDEX   = 5'd31;
  // Top of the 512 KiB data memory.
  localparam reg_word_t STACK_INIT = 64'sd524288;

endpackage

// File: rtl/tinker_regfile_rport.sv
// One registered read port: write-bypass compare, operand select and output register.
module tinker_regfile_rport
  import tinker_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_rd_req,
  input  reg_addr_t i_addr,
  input  reg_word_t i_store_data,
  input  logic      i_wr_en,
  input  reg_addr_t i_wr_addr,
  input  reg_word_t i_wr_data,
  output reg_word_t o_data
);

  logic      w_bypass;
  reg_word_t w_sel;
  reg_word_t r_data;

  // A same-cycle write to the addressed register wins over stale storage.
  assign w_bypass = i_wr_en && (i_wr_addr == i_addr);
  assign w_sel    = w_bypass ? i_wr_data : i_store_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (i_rd_req) begin
      r_data <= w_sel;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/tinker_regfile.sv
// Tinker architectural register file: 32 x 64-bit, three registered read ports, one write port.
module tinker_regfile #(
  parameter int unsigned                  NUM_REGS   = tinker_pkg::REG_COUNT,
  parameter int unsigned                  DATA_WIDTH = tinker_pkg::DATA_WIDTH,
  parameter int unsigned                  ADDR_WIDTH = tinker_pkg::REG_ADDR_WIDTH,
  parameter logic signed [DATA_WIDTH-1:0] STACK_INIT = tinker_pkg::STACK_INIT
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_rd_req,
  input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
  input  logic [ADDR_WIDTH-1:0]        i_rs_addr,
  input  logic [ADDR_WIDTH-1:0]        i_rt_addr,
  input  logic                         i_wr_en,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  output logic signed [DATA_WIDTH-1:0] o_rd_data,
  output logic signed [DATA_WIDTH-1:0] o_rs_data,
  output logic signed [DATA_WIDTH-1:0] o_rt_data,
  output logic                         o_rd_valid,
  output logic signed [DATA_WIDTH-1:0] o_stack_ptr
);
  import tinker_pkg::*;

  logic signed [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                         r_rd_valid;

  // Reset takes priority, so a write presented alongside reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == 32'(SP_INDEX)) ? STACK_INIT : '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_req;
    end
  end

  tinker_regfile_rport u_rport_rd (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rd_req    (i_rd_req),
    .i_addr      (i_rd_addr),
    .i_store_data(r_regs[i_rd_addr]),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_data      (o_rd_data)
  );

  tinker_regfile_rport u_rport_rs (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rd_req    (i_rd_req),
    .i_addr      (i_rs_addr),
    .i_store_data(r_regs[i_rs_addr]),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_data      (o_rs_data)
  );

  tinker_regfile_rport u_rport_rt (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rd_req    (i_rd_req),
    .i_addr      (i_rt_addr),
    .i_store_data(r_regs[i_rt_addr]),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_data      (o_rt_data)
  );

  assign o_rd_valid  = r_rd_valid;
  assign o_stack_ptr = r_regs[SP_INDEX];

endmodule

// File: doc/tinker_regfile.md
# tinker_regfile

Architectural register file for the Tinker core: 32 signed 64-bit general registers, three registered read ports (rd, rs, rt) and one write port. It sits directly upstream of the 64-bit pipeline latch, supplying operands one cycle after a read request, and downstream of writeback. r31 is the stack pointer and resets to the top of data memory.

## Interface
- NUM_REGS, 32, register count (fixed at 32 for the Tinker ISA)
- DATA_WIDTH, 64, register width in bits, signed
- ADDR_WIDTH, 5, register index width
- STACK_INIT, 524288, reset value of r31 (512 KiB memory top)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_req  in  1  read request; samples rd_addr/rs_addr/rt_addr this cycle
- rd_addr, rs_addr, rt_addr  in  5 each  source register indices
- wr_en  in  1  write enable
- wr_addr  in  5  destination index
- wr_data  in  64 signed  write value
- rd_data, rs_data, rt_data  out  64 signed each  registered operand values
- rd_valid  out  1  operands valid; high exactly one cycle after an accepted rd_req
- stack_ptr  out  64 signed  live r31 contents (combinational from storage)

## Operation
- Reset (reset=1 at edge): r0–r30 ← 0, r31 ← STACK_INIT; rd_data/rs_data/rt_data ← 0; rd_valid ← 0; wr_en and rd_req ignored that cycle.
- Write: wr_en=1 at edge (reset=0) → reg[wr_addr] ← wr_data. All 32 registers writable, including r0 and r31.
- Read: rd_req=1 at edge → each *_data output ← current value of its addressed register; rd_valid ← 1. rd_req=0 → rd_valid ← 0, *_data hold previous values.
- Write-read bypass: same-cycle rd_req and wr_en with matching address → that port captures wr_data, not stale storage. Applies independently to each port; multiple ports may match.
- Back-to-back rd_req every cycle supported; one result per cycle, no stall.
- No arithmetic; values pass bit-exact. Signedness only affects consumers.
- stack_ptr reflects a write to r31 starting the cycle after the write edge.

## Timing
- Read latency: 1 cycle (request edge N → data and rd_valid valid after edge N, consumed at edge N+1).
- Write latency: stored at edge; visible via normal read from the next request onward, via bypass in the same cycle.
- Reset mid-read: rd_req at edge N, reset at edge N+1 → rd_valid 0 after N+1, outputs 0; request lost, no replay.
- Reset dominates: reset with wr_en=1 → write discarded, register takes reset value.
- Back-to-back writes to the same address: last edge wins.

## Structure
- Shared package tinker_pkg: DATA_WIDTH, REG_COUNT, REG_ADDR_WIDTH, SP_INDEX=31, STACK_INIT, typedef reg_word_t (signed 64-bit), reg_addr_t (5-bit).
- One sub-module is natural: tinker_regfile_rport — bypass compare, mux, output register; instantiated three times. Storage array and write logic stay in the top.

## Test plan
- Reset: assert reset 2 cycles, then rd_req with rd/rs/rt = 0,30,31 → rd_valid=1 next cycle, data 0, 0, 524288; stack_ptr=524288.
- Write then read: write r5 ← 0xDB6DB6DB6DB6DB6D, next cycle rd_req rs=5 → rs_data=0xDB6DB6DB6DB6DB6D (negative signed), rd_valid=1.
- Bypass: same cycle wr_en r7 ← -1 and rd_req rd=7, rs=7, rt=8 → rd_data=rs_data=0xFFFFFFFFFFFFFFFF, rt_data=0.
- Stack pointer: write r31 ← 0x1000 → stack_ptr=0x1000 next cycle; reset → 524288.
- Reset mid-operation: rd_req at edge N, reset at N+1 with wr_en r3 ← 9 → rd_valid=0, outputs 0, later read of r3 returns 0.
- Streaming: rd_req every cycle for 32 cycles, rs_addr=i after writing reg[i]=i*3 → rs_data sequence 0,3,…,93, rd_valid continuously high; drop rd_req → rd_valid 0, data held.
